// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared pipeline-control types and forwarding select encodings
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hazard_state_t;

  // Shared with the forwarding unit so both agree on operand-select encodings
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-low reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use/MDU stall and taken-branch flush control with statistics
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_is_mdu,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  ID_EX_write,
  output logic                  ID_EX_bubble,
  output logic                  IF_ID_flush,
  output logic                  EX_MEM_bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int MC_W = $clog2(MDU_LAT);
  // Entry cycle is the first hold, so the counter covers the remaining MDU_LAT-2 holds
  localparam logic [MC_W-1:0] MDU_RELOAD = MC_W'(MDU_LAT - 2);

  hazard_state_t   state, next_state;
  logic [MC_W-1:0] mdu_cnt, next_mdu_cnt;
  logic            load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_rt != '0) &&
                    ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    IF_ID_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    next_state    = state;
    next_mdu_cnt  = mdu_cnt;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (ID_EX_is_mdu) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
            next_state    = MDU_BUSY;
            next_mdu_cnt  = MDU_RELOAD;
          end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
        MDU_BUSY: begin
          // EX still holds the MDU op, so branch and load-use are not evaluated here
          if (mdu_cnt != '0) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_bubble = 1'b1;
            next_mdu_cnt  = mdu_cnt - 1'b1;
          end else begin
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= next_state;
      mdu_cnt <= next_mdu_cnt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed self-check of hazard_control_unit
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] if_rs = '0, if_rt = '0, ex_rt = '0;
  logic       mem_read = 1'b0, is_mdu = 1'b0, br = 1'b0;

  logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush, ex_mem_bubble;
  logic [15:0] stall_count, flush_count;
  logic        pc_write2, if_id_write2, id_ex_write2, id_ex_bubble2, if_id_flush2, ex_mem_bubble2;
  logic [1:0]  stall_count2, flush_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .MDU_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs(if_rs), .IF_ID_rt(if_rt), .ID_EX_rt(ex_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_is_mdu(is_mdu), .branch_taken(br),
    .pc_write(pc_write), .IF_ID_write(if_id_write), .ID_EX_write(id_ex_write),
    .ID_EX_bubble(id_ex_bubble), .IF_ID_flush(if_id_flush), .EX_MEM_bubble(ex_mem_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .MDU_LAT(LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs(if_rs), .IF_ID_rt(if_rt), .ID_EX_rt(ex_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_is_mdu(is_mdu), .branch_taken(br),
    .pc_write(pc_write2), .IF_ID_write(if_id_write2), .ID_EX_write(id_ex_write2),
    .ID_EX_bubble(id_ex_bubble2), .IF_ID_flush(if_id_flush2), .EX_MEM_bubble(ex_mem_bubble2),
    .stall_count(stall_count2), .flush_count(flush_count2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ex_age counts cycles the MDU op has already spent in EX (0 = none)
  int  ex_age = 0;
  int  m_stall = 0, m_flush = 0;
  bit  model_valid = 0;

  typedef struct packed {
    logic pc, ifw, exw, exb, flush, memb;
  } ctl_t;

  function automatic ctl_t model_ctl();
    ctl_t c;
    bit lu;
    c = '{pc: 1, ifw: 1, exw: 1, exb: 0, flush: 0, memb: 0};
    lu = mem_read && ex_rt != 0 && (ex_rt == if_rs || ex_rt == if_rt);
    if (!rst_n) return c;
    if (ex_age > 0) begin
      if (ex_age < LAT - 1) c = '{pc: 0, ifw: 0, exw: 0, exb: 0, flush: 0, memb: 1};
    end else if (br) begin
      c.flush = 1; c.exb = 1;
    end else if (is_mdu) begin
      c = '{pc: 0, ifw: 0, exw: 0, exb: 0, flush: 0, memb: 1};
    end else if (lu) begin
      c.pc = 0; c.ifw = 0; c.exb = 1;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    ctl_t c;
    c = model_ctl();
    if (!rst_n) begin
      model_valid = 1;
      ex_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!c.pc) m_stall++;
      if (c.flush) m_flush++;
      if (ex_age > 0) ex_age = (ex_age == LAT - 1) ? 0 : ex_age + 1;
      else if (!br && is_mdu) ex_age = 1;
    end
  end

  always @(negedge clk) begin
    ctl_t c;
    if (model_valid) begin
      c = model_ctl();
      check("pc_write", int'(pc_write), int'(c.pc));
      check("IF_ID_write", int'(if_id_write), int'(c.ifw));
      check("ID_EX_write", int'(id_ex_write), int'(c.exw));
      check("ID_EX_bubble", int'(id_ex_bubble), int'(c.exb));
      check("IF_ID_flush", int'(if_id_flush), int'(c.flush));
      check("EX_MEM_bubble", int'(ex_mem_bubble), int'(c.memb));
      check("stall_count", int'(stall_count), (m_stall > 65535) ? 65535 : m_stall);
      check("flush_count", int'(flush_count), (m_flush > 65535) ? 65535 : m_flush);
      check("stall_count_w2", int'(stall_count2), (m_stall > 3) ? 3 : m_stall);
      check("flush_count_w2", int'(flush_count2), (m_flush > 3) ? 3 : m_flush);
      check("pc_write_w2", int'(pc_write2), int'(c.pc));
    end
  end

  task automatic apply(input logic r, input logic mr, input logic mdu, input logic b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt);
    @(posedge clk);
    #1;
    rst_n = r; mem_read = mr; is_mdu = mdu; br = b;
    if_rs = rs; if_rt = rt; ex_rt = xrt;
  endtask

  task automatic idle();
    apply(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit hold_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    do_reset();
    @(negedge clk);
    check("reset_pc_write", int'(pc_write), 1);
    check("reset_stall_count", int'(stall_count), 0);

    // Load-use single stall, then r0 destination never stalls
    apply(1, 1, 0, 0, 5, 1, 5);
    @(negedge clk);
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_IF_ID_write", int'(if_id_write), 0);
    check("lu_ID_EX_bubble", int'(id_ex_bubble), 1);
    idle();
    @(negedge clk);
    check("lu_stall_count", int'(stall_count), 1);
    apply(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("lu_r0_pc_write", int'(pc_write), 1);
    idle();
    @(negedge clk);
    check("lu_r0_stall_count", int'(stall_count), 1);

    // Back-to-back MDU: 3 holds, advance, 3 holds, advance
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("mdu_pc_write", int'(pc_write), hold_pat[i] ? 0 : 1);
      check("mdu_EX_MEM_bubble", int'(ex_mem_bubble), hold_pat[i] ? 1 : 0);
      if (i == 4) check("mdu_first_stall_count", int'(stall_count), 3);
    end
    idle();
    @(negedge clk);
    check("mdu_b2b_stall_count", int'(stall_count), 6);

    // Branch beats load-use
    do_reset();
    apply(1, 1, 0, 1, 5, 0, 5);
    @(negedge clk);
    check("br_IF_ID_flush", int'(if_id_flush), 1);
    check("br_ID_EX_bubble", int'(id_ex_bubble), 1);
    check("br_pc_write", int'(pc_write), 1);
    idle();
    @(negedge clk);
    check("br_flush_count", int'(flush_count), 1);
    check("br_stall_count", int'(stall_count), 0);

    // Reset on the second MDU hold cycle
    do_reset();
    apply(1, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_mid_pc_write", int'(pc_write), 1);
    check("rst_mid_EX_MEM_bubble", int'(ex_mem_bubble), 0);
    idle();
    @(negedge clk);
    check("rst_after_pc_write", int'(pc_write), 1);
    check("rst_after_stall_count", int'(stall_count), 0);
    check("rst_after_flush_count", int'(flush_count), 0);

    // Saturation of the 2-bit counters
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0, 0, 0, 7, 7);
      idle();
    end
    @(negedge clk);
    check("sat_stall_count_w2", int'(stall_count2), 3);
    check("sat_stall_count_w16", int'(stall_count), 5);

    // Randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage core; companion to the data forwarding unit. It covers the hazards that forwarding cannot resolve: load-use stalls, multi-cycle multiply/divide occupancy of EX, and taken-branch flushes. It drives the PC/pipeline-register write enables, the bubble and flush controls, and saturating stall/flush statistics counters.

## Interface
- REG_ADDR_W, 5, register address width
- MDU_LAT, 4, cycles an MDU instruction occupies EX (legal range 2..16)
- CNT_W, 16, width of statistics counters

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- IF_ID_rs  in  REG_ADDR_W  source register 1 of instruction in decode
- IF_ID_rt  in  REG_ADDR_W  source register 2 of instruction in decode
- ID_EX_rt  in  REG_ADDR_W  destination register of load in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_is_mdu  in  1  instruction in EX is multiply/divide
- branch_taken  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register write enable
- ID_EX_write  out  1  ID/EX register write enable
- ID_EX_bubble  out  1  load zeroed controls into ID/EX
- IF_ID_flush  out  1  clear IF/ID to NOP
- EX_MEM_bubble  out  1  load zeroed controls into EX/MEM
- stall_count  out  CNT_W  cycles with pc_write=0, saturating
- flush_count  out  CNT_W  branch flushes taken, saturating

## Operation
- FSM states: RUN, MDU_BUSY. Down-counter mdu_cnt, width ceil(log2(MDU_LAT)).
- Outputs are combinational from state, mdu_cnt and the current inputs. Default: all three write enables = 1; all bubble/flush = 0.
- Load-use hazard = ID_EX_MemRead && ID_EX_rt != 0 && (ID_EX_rt == IF_ID_rs || ID_EX_rt == IF_ID_rt).
- RUN priority, highest first:
  - branch_taken: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count++. Stay in RUN. Wins over MDU and load-use.
  - ID_EX_is_mdu: pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1; mdu_cnt <= MDU_LAT-2; go to MDU_BUSY.
  - load-use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1. Stay in RUN. The next cycle sees the bubble in EX, so the stall lasts exactly 1 cycle.
- MDU_BUSY:
  - mdu_cnt != 0: same hold outputs as MDU entry; mdu_cnt--.
  - mdu_cnt == 0: default outputs, so the MDU result advances; go to RUN.
  - branch_taken and load-use are ignored, because EX holds the MDU instruction.
- Counters:
  - stall_count increments on every non-reset cycle with pc_write=0.
  - flush_count increments on every cycle with IF_ID_flush=1.
  - Both hold at 2^CNT_W-1.

## Timing
- Reset: while rst_n=0 at a clock edge, state <= RUN, mdu_cnt <= 0, counters <= 0. While rst_n=0, outputs are forced to the defaults (write enables 1, bubble/flush 0) regardless of inputs. Reset during MDU_BUSY aborts the hold immediately.
- Latency:
  - load-use costs 1 stall cycle.
  - MDU instruction costs MDU_LAT-1 stall cycles (EX residency MDU_LAT).
  - taken branch costs 2 squashed slots in the same cycle; no stall.
- Same-cycle stall/flush response is combinational. State and counters update at the clk edge.
- Counter outputs reflect events up to the previous edge.
- An MDU instruction arriving in EX on the cycle after MDU_BUSY exits re-enters MDU_BUSY with no RUN gap.

## Structure
- Package hazard_pkg:
  - state typedef (RUN, MDU_BUSY).
  - forwarding select constants FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, shared with the forwarding unit.
- One sub-module: sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_count=1. Repeat with ID_EX_rt=0 -> no stall.
- MDU, MDU_LAT=4: ID_EX_is_mdu held -> 3 cycles of all write enables 0 and EX_MEM_bubble=1, then 1 advance cycle; stall_count=3.
- Branch vs load-use: branch_taken=1 with a load-use match -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count=1; stall_count unchanged.
- Reset mid-MDU: rst_n=0 on the 2nd hold cycle -> next cycle state RUN, outputs default, both counters 0.
- Saturation, CNT_W=2: 5 load-use stalls -> stall_count=3.
- Back-to-back MDU: second MDU enters EX right after the first exits -> 3 holds, 1 advance, 3 holds; stall_count=6.
